// File: rtl/intr_pkg.sv
// Shared types and register map offsets for the RAT MCU interrupt controller.
package intr_pkg;

  // Controller states: waiting for a candidate, requesting the CPU, or in service.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;

  // Register offsets from the I/O base port ID.
  localparam logic [7:0] OFS_MASK = 8'd0;
  localparam logic [7:0] OFS_PEND = 8'd1;
  localparam logic [7:0] OFS_VEC  = 8'd2;

endpackage

// File: rtl/intr_if.sv
// MCU-side bus for the interrupt controller: the I/O register port plus the
// interrupt handshake with the control unit.
interface intr_if;

  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] rd_data;
  logic       intr;
  logic       intr_ack;
  logic       eoi;
  logic [2:0] vector;

  modport master (
    output port_id, out_port, io_strb, intr_ack, eoi,
    input  rd_data, intr, vector
  );

  modport slave (
    input  port_id, out_port, io_strb, intr_ack, eoi,
    output rd_data, intr, vector
  );

endinterface

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder for up to eight request lines.
module prio_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge detection, pending/mask registers on the
// I/O bus, fixed-priority selection and a request/service handshake FSM.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int         NUM_SRC = 4,
  parameter logic [7:0] IO_BASE = 8'h40
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  intr_if.slave              bus
);

  localparam logic [7:0] ADDR_MASK = IO_BASE + OFS_MASK;
  localparam logic [7:0] ADDR_PEND = IO_BASE + OFS_PEND;
  localparam logic [7:0] ADDR_VEC  = IO_BASE + OFS_VEC;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_n;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [7:0]         cand8;
  logic [7:0]         clr_onehot;
  logic [2:0]         vector_q;
  logic [2:0]         vector_n;
  logic [2:0]         win_idx;
  logic               win_valid;
  logic               ack_clr;
  logic               mask_wr;
  logic               pend_wr;
  logic               unused_out;
  state_t             state_q;
  state_t             state_n;

  assign rise       = src & ~src_q;
  assign cand       = pend_q & mask_q;
  assign cand8      = 8'(cand);
  assign mask_wr    = bus.io_strb && (bus.port_id == ADDR_MASK);
  assign pend_wr    = bus.io_strb && (bus.port_id == ADDR_PEND);
  assign unused_out = &{1'b0, bus.out_port};

  prio_enc #(.W(NUM_SRC)) u_prio (
    .req   (cand),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // One-cycle delayed copy of the request lines for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) src_q <= '0;
    else          src_q <= src;
  end

  // Software-writable enable mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     mask_q <= '0;
    else if (mask_wr) mask_q <= bus.out_port[NUM_SRC-1:0];
  end

  // Next pending value: clears first, then new edges so a set always wins.
  always_comb begin
    clr_onehot = 8'b1 << vector_q;
    pend_n     = pend_q;
    if (pend_wr) pend_n = pend_n & ~bus.out_port[NUM_SRC-1:0];
    if (ack_clr) pend_n = pend_n & ~clr_onehot[NUM_SRC-1:0];
    pend_n = pend_n | rise;
  end

  // Pending, state and vector registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      state_q  <= ST_IDLE;
      vector_q <= 3'd0;
    end else begin
      pend_q   <= pend_n;
      state_q  <= state_n;
      vector_q <= vector_n;
    end
  end

  // Handshake FSM; a withdrawn source drops the request before any ack counts.
  always_comb begin
    state_n  = state_q;
    vector_n = vector_q;
    ack_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          vector_n = win_idx;
          state_n  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!cand8[vector_q]) begin
          state_n = ST_IDLE;
        end else if (bus.intr_ack) begin
          ack_clr = 1'b1;
          state_n = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.eoi) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.intr   = (state_q == ST_REQ);
  assign bus.vector = vector_q;

  // Combinational register read mux; unmapped ports read zero.
  always_comb begin
    bus.rd_data = 8'h00;
    if (bus.port_id == ADDR_MASK)      bus.rd_data = 8'(mask_q);
    else if (bus.port_id == ADDR_PEND) bus.rd_data = 8'(pend_q);
    else if (bus.port_id == ADDR_VEC)  bus.rd_data = {5'b0, vector_q};
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
module tb_intr_ctrl;

  localparam int NSRC = 4;
  localparam int BASE = 'h40;
  localparam int LIM  = (1 << NSRC) - 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NSRC-1:0] src = '0;
  int              checks = 0;
  int              errors = 0;

  // Model state: mode 0 = waiting, 1 = requesting, 2 = in service.
  int m_mask, m_pend, m_mode, m_vec, m_prev;

  intr_if bus ();

  intr_ctrl #(.NUM_SRC(NSRC), .IO_BASE(8'h40)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .src     (src),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int exp_rd(input int pid);
    if (pid == BASE)     return m_mask;
    if (pid == BASE + 1) return m_pend;
    if (pid == BASE + 2) return m_vec;
    return 0;
  endfunction

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_mode = 0; m_vec = 0; m_prev = 0;
  endtask

  // Advance the model by one clock using the inputs the bench is driving.
  task automatic model_update();
    int cand, rise, clr, nxt;
    clr  = 0;
    cand = m_pend & m_mask;
    rise = int'(src) & ~m_prev & LIM;
    m_prev = int'(src);
    case (m_mode)
      0: if (cand != 0) begin m_vec = lowest(cand); m_mode = 1; end
      1: begin
        if (((cand >> m_vec) & 1) == 0) m_mode = 0;
        else if (bus.intr_ack) begin clr = 1 << m_vec; m_mode = 2; end
      end
      default: if (bus.eoi) m_mode = 0;
    endcase
    nxt = m_pend;
    if (bus.io_strb && int'(bus.port_id) == BASE + 1) nxt = nxt & ~int'(bus.out_port);
    nxt = (nxt & ~clr) | rise;
    m_pend = nxt & LIM;
    if (bus.io_strb && int'(bus.port_id) == BASE) m_mask = int'(bus.out_port) & LIM;
  endtask

  // Drive one cycle of inputs, clock, then compare outputs with the model.
  task automatic apply_stimulus(input logic [NSRC-1:0] s, input logic [7:0] pid,
                                input logic [7:0] data, input logic strb,
                                input logic ack, input logic e);
    src = s; bus.port_id = pid; bus.out_port = data;
    bus.io_strb = strb; bus.intr_ack = ack; bus.eoi = e;
    @(posedge clk);
    model_update();
    #1;
    check_output("intr", int'(bus.intr), (m_mode == 1) ? 1 : 0);
    check_output("vector", int'(bus.vector), m_vec);
    check_output("rd_data", int'(bus.rd_data), exp_rd(int'(pid)));
    bus.io_strb = 1'b0; bus.intr_ack = 1'b0; bus.eoi = 1'b0;
  endtask

  task automatic idle_cycle(input logic [NSRC-1:0] s);
    apply_stimulus(s, 8'h42, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and confirm everything is cleared at once.
  task automatic async_reset_check();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_output("rst_intr", int'(bus.intr), 0);
    check_output("rst_vector", int'(bus.vector), 0);
    bus.port_id = 8'h40; #0.1;
    check_output("rst_mask", int'(bus.rd_data), 0);
    bus.port_id = 8'h41; #0.1;
    check_output("rst_pend", int'(bus.rd_data), 0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bus.port_id = 8'h00; bus.out_port = 8'h00; bus.io_strb = 1'b0;
    bus.intr_ack = 1'b0; bus.eoi = 1'b0;
    model_reset();
    #3;
    check_output("reset_intr", int'(bus.intr), 0);
    check_output("reset_vector", int'(bus.vector), 0);
    #14 reset_n = 1'b1;

    $display("[TB] basic");
    apply_stimulus(4'b0000, 8'h40, 8'h04, 1'b1, 1'b0, 1'b0);
    idle_cycle(4'b0100);
    check_output("basic_no_intr_yet", int'(bus.intr), 0);
    idle_cycle(4'b0000);
    check_output("basic_intr", int'(bus.intr), 1);
    check_output("basic_vec", int'(bus.vector), 2);
    apply_stimulus(4'b0000, 8'h41, 8'h00, 1'b0, 1'b1, 1'b0);
    check_output("basic_pend_clr", int'(bus.rd_data), 0);
    apply_stimulus(4'b0000, 8'h42, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] priority");
    apply_stimulus(4'b0000, 8'h40, 8'h0F, 1'b1, 1'b0, 1'b0);
    idle_cycle(4'b1010);
    idle_cycle(4'b0000);
    check_output("prio_first", int'(bus.vector), 1);
    apply_stimulus(4'b0000, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(4'b0000, 8'h42, 8'h00, 1'b0, 1'b0, 1'b1);
    idle_cycle(4'b0000);
    check_output("prio_second_vec", int'(bus.vector), 3);
    check_output("prio_second_intr", int'(bus.intr), 1);
    apply_stimulus(4'b0000, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(4'b0000, 8'h42, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] masking and withdrawal");
    apply_stimulus(4'b0000, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
    idle_cycle(4'b0001);
    apply_stimulus(4'b0000, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0);
    check_output("mask_pend", int'(bus.rd_data), 1);
    check_output("mask_no_intr", int'(bus.intr), 0);
    apply_stimulus(4'b0000, 8'h40, 8'h01, 1'b1, 1'b0, 1'b0);
    idle_cycle(4'b0000);
    check_output("unmask_intr", int'(bus.intr), 1);
    apply_stimulus(4'b0000, 8'h41, 8'h01, 1'b1, 1'b0, 1'b0);
    idle_cycle(4'b0000);
    check_output("withdraw_intr", int'(bus.intr), 0);

    $display("[TB] simultaneous set and clear");
    apply_stimulus(4'b0001, 8'h41, 8'h01, 1'b1, 1'b0, 1'b0);
    check_output("setclr_pend", int'(bus.rd_data), 1);
    idle_cycle(4'b0000);
    apply_stimulus(4'b0000, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] service hold");
    idle_cycle(4'b0001);
    idle_cycle(4'b0000);
    idle_cycle(4'b0000);
    check_output("svc_hold_intr", int'(bus.intr), 0);
    apply_stimulus(4'b0000, 8'h42, 8'h00, 1'b0, 1'b0, 1'b1);
    idle_cycle(4'b0000);
    check_output("svc_rereq_intr", int'(bus.intr), 1);
    check_output("svc_rereq_vec", int'(bus.vector), 0);

    $display("[TB] async reset mid-request");
    async_reset_check();

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      logic [7:0] pid;
      int sel;
      sel = $urandom_range(0, 5);
      pid = (sel < 4) ? 8'(BASE + sel) : 8'($urandom);
      apply_stimulus(4'($urandom), pid, 8'($urandom),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 99) == 0) async_reset_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
